// File: rtl/enemy_counter.sv
// enemy_counter: tracks enemies remaining in the current wave and sequences
// waves through to the end of the game.
//
// Build option: define HIT_EDGE_DETECT_EN to count a hit only on a rising
// edge of hit (a held level counts once). When it is undefined, every
// ACTIVE cycle with hit=1 counts.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the first start; counter parked at WAVE_SIZE
// ACTIVE  | wave in progress; accepted hits decrement the counter
// CLEARED | wave finished; start begins the next wave or ends the game
// DONE    | final wave cleared and acknowledged; frozen until rst
module enemy_counter #(
  parameter int WAVE_SIZE = 8,
  parameter int N_WAVES   = 4
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       hit,
  input  logic       start,
  output logic [3:0] signal_counter,
  output logic [2:0] wave_num,
  output logic       wave_cleared,
  output logic       game_done
);

  localparam logic [3:0] WAVE_INIT = 4'(WAVE_SIZE);
  localparam logic [2:0] LAST_WAVE = 3'(N_WAVES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    CLEARED = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] wave_q, wave_d;
  logic       clr_q, clr_d;
  logic       done_q, done_d;
  logic       hit_acc;

`ifdef HIT_EDGE_DETECT_EN
  logic hit_q;

  // Remember last cycle's hit so a held level is only counted once.
  always_ff @(posedge pclk) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit;
  end

  assign hit_acc = hit & ~hit_q;
`else
  assign hit_acc = hit;
`endif

  // Next-state and next-output decode; every target gets a default first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wave_d  = wave_q;
    clr_d   = 1'b0;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        cnt_d  = WAVE_INIT;
        wave_d = 3'd0;
        if (start) state_d = ACTIVE;
      end
      ACTIVE: begin
        // start is meaningless mid-wave; only hits matter here.
        if (hit_acc && (cnt_q != 4'd0)) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = CLEARED;
            clr_d   = 1'b1;
          end
        end
      end
      CLEARED: begin
        if (start) begin
          if (wave_q == LAST_WAVE) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ACTIVE;
            wave_d  = wave_q + 3'd1;
            cnt_d   = WAVE_INIT;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = WAVE_INIT;
        wave_d  = 3'd0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset parks the counter at WAVE_SIZE so it
  // never reads zero before a wave has actually been cleared.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= WAVE_INIT;
      wave_q  <= 3'd0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wave_q  <= wave_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  assign signal_counter = cnt_q;
  assign wave_num       = wave_q;
  assign wave_cleared   = clr_q;
  assign game_done      = done_q;

endmodule
